// File: rtl/twiddle_gen.sv
// Sequenced FP16 twiddle-factor generator for radix-2 DIF FFT stages (N = 4..64).
// A quarter-wave cosine ROM plus symmetry yields each stage's N/2 twiddles over valid/ready.
module twiddle_gen #(
  parameter int LOG2N = 4,
  parameter int DW    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [2:0]        stage,
  input  logic              inverse,
  output logic              busy,
  output logic              err,
  output logic              tw_valid,
  input  logic              tw_ready,
  output logic [2*DW-1:0]   tw_data,
  output logic [LOG2N-2:0]  tw_k,
  output logic              tw_last
);
  localparam int KW   = LOG2N - 1;
  localparam int HALF = 1 << (LOG2N - 1);
  localparam int QTR  = 1 << (LOG2N - 2);
  localparam int SH   = 6 - LOG2N;
  localparam logic [LOG2N-1:0] HALF_V = LOG2N'(HALF);
  localparam logic [LOG2N-1:0] QTR_V  = LOG2N'(QTR);
  localparam logic [KW-1:0]    LAST_C = KW'(HALF - 1);
  localparam logic [2:0]       STAGES = 3'(LOG2N);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;

  // c64[m] = FP16(cos(2*pi*m/64)), m = 0..16
  function automatic logic [15:0] cos64(input logic [4:0] m);
    case (m)
      5'd0:    cos64 = 16'h3C00;
      5'd1:    cos64 = 16'h3BF6;
      5'd2:    cos64 = 16'h3BD9;
      5'd3:    cos64 = 16'h3BA8;
      5'd4:    cos64 = 16'h3B64;
      5'd5:    cos64 = 16'h3B0E;
      5'd6:    cos64 = 16'h3AA7;
      5'd7:    cos64 = 16'h3A2F;
      5'd8:    cos64 = 16'h39A8;
      5'd9:    cos64 = 16'h3913;
      5'd10:   cos64 = 16'h3872;
      5'd11:   cos64 = 16'h378B;
      5'd12:   cos64 = 16'h361F;
      5'd13:   cos64 = 16'h34A5;
      5'd14:   cos64 = 16'h323E;
      5'd15:   cos64 = 16'h2E46;
      default: cos64 = 16'h0000;
    endcase
  endfunction

  function automatic logic [15:0] cos_n(input logic [LOG2N-1:0] m);
    logic [4:0] idx;
    idx = 5'(m);
    idx = idx << SH;
    return cos64(idx);
  endfunction

  // Sign flip that never produces negative zero.
  function automatic logic [15:0] neg16(input logic [15:0] x);
    logic [15:0] r;
    if (x[14:0] == 15'd0) r = 16'h0000;
    else                  r = {~x[15], x[14:0]};
    return r;
  endfunction

  state_t           state_r, state_s;
  logic [KW-1:0]    cnt_r, cnt_s;
  logic [2:0]       stage_r, stage_s;
  logic             inv_r, inv_s;
  logic             busy_s, err_s, valid_s, last_s;
  logic [2*DW-1:0]  data_s;
  logic [KW-1:0]    tk_s;
  logic [KW-1:0]    mask_s, k_s;
  logic [LOG2N-1:0] kk_s;
  logic [15:0]      re_s, im_s, imo_s;

  // Exponent for the current count and its symmetry-mapped twiddle.
  always_comb begin
    mask_s = KW'((HALF >> stage_r) - 1);
    k_s    = (cnt_r & mask_s) << stage_r;
    kk_s   = {1'b0, k_s};
    if (kk_s <= QTR_V) begin
      re_s = cos_n(kk_s);
      im_s = neg16(cos_n(QTR_V - kk_s));
    end else begin
      re_s = neg16(cos_n(HALF_V - kk_s));
      im_s = neg16(cos_n(kk_s - QTR_V));
    end
    imo_s = inv_r ? neg16(im_s) : im_s;
  end

  // Next-state and next-output logic.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    stage_s = stage_r;
    inv_s   = inv_r;
    busy_s  = busy;
    err_s   = 1'b0;
    valid_s = tw_valid;
    data_s  = tw_data;
    tk_s    = tw_k;
    last_s  = tw_last;
    case (state_r)
      IDLE: begin
        if (start) begin
          if (stage < STAGES) begin
            stage_s = stage;
            inv_s   = inverse;
            cnt_s   = '0;
            busy_s  = 1'b1;
            state_s = RUN;
          end else begin
            err_s = 1'b1;
          end
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (!tw_valid || tw_ready) begin
          valid_s = 1'b1;
          data_s  = 32'({re_s, imo_s});
          tk_s    = k_s;
          last_s  = (cnt_r == LAST_C);
          cnt_s   = cnt_r + KW'(1);
          if (cnt_r == LAST_C) state_s = DRAIN;
          else                 state_s = RUN;
        end else begin
          state_s = RUN;
        end
      end
      DRAIN: begin
        if (tw_valid && tw_ready) begin
          valid_s = 1'b0;
          last_s  = 1'b0;
          busy_s  = 1'b0;
          state_s = IDLE;
        end else begin
          state_s = DRAIN;
        end
      end
      default: begin
        state_s = IDLE;
        busy_s  = 1'b0;
        valid_s = 1'b0;
        last_s  = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= IDLE;
      cnt_r    <= '0;
      stage_r  <= 3'd0;
      inv_r    <= 1'b0;
      busy     <= 1'b0;
      err      <= 1'b0;
      tw_valid <= 1'b0;
      tw_data  <= '0;
      tw_k     <= '0;
      tw_last  <= 1'b0;
    end else begin
      state_r  <= state_s;
      cnt_r    <= cnt_s;
      stage_r  <= stage_s;
      inv_r    <= inv_s;
      busy     <= busy_s;
      err      <= err_s;
      tw_valid <= valid_s;
      tw_data  <= data_s;
      tw_k     <= tk_s;
      tw_last  <= last_s;
    end
  end
endmodule

// File: doc/twiddle_gen.md
Name: twiddle_gen

Overview:
Parametrised, sequenced twiddle-factor generator for the radix-2 DIF FFT datapath. It replaces the fixed 8-entry 16-point twiddle table. It covers N = 4..64 points (N = 2^LOG2N) and stores only a quarter-wave cosine table in IEEE-754 half precision, deriving all other twiddles by symmetry. It streams the N/2 twiddles of one stage to the butterfly unit over a valid/ready handshake and supports conjugated (IFFT) output.

Parameters:
LOG2N, 4, log2 of FFT size. Legal range 2..6.
DW, 16, width of one FP16 component. Fixed at 16; any other value is illegal.

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous reset, active-high
start  input  1  request to stream one stage; honoured only when busy=0
stage  input  3  DIF stage index s, sampled with an accepted start
inverse  input  1  sampled with an accepted start; 1 = conjugate all outputs for IFFT
busy  output  1  high from accepted start until the last twiddle handshake completes
err  output  1  one-cycle pulse: start seen with busy=0 and stage >= LOG2N
tw_valid  output  1  tw_data, tw_k and tw_last are valid
tw_ready  input  1  consumer accepts the current twiddle
tw_data  output  2*DW  {re[15:0], im[15:0]} of W_N^k = cos(2πk/N) - j·sin(2πk/N)
tw_k  output  LOG2N-1  exponent k of the current twiddle (width LOG2N-1 for a valid range 0..N/2-1)
tw_last  output  1  marks the final (N/2-th) twiddle of the stage

Behaviour:
- Reset (clk edge with rst=1): busy=0, err=0, tw_valid=0, tw_data=0, tw_k=0, tw_last=0, counter=0, FSM=IDLE. rst overrides everything, including mid-stream; the partial stage is discarded and no tw_last is emitted.
- Cosine ROM: 17 entries c64[m] = FP16(cos(2πm/64)), m = 0..16. Anchors: c64[0]=3C00, c64[4]=3B64, c64[8]=39A8, c64[12]=361F, c64[16]=0000. Indexing uses c[m] = c64[m << (6-LOG2N)], so Q = N/4.
- Symmetry mapping for k in 0..N/2-1:
  - k <= Q: re = c[k], im = -c[Q-k].
  - k > Q: re = -c[N/2-k], im = -c[k-Q].
- Negation is a bit-15 flip. A component whose magnitude is 0 is always output as 16'h0000; negative zero is never produced.
- inverse=1 flips the sign of im after mapping, with the same zero rule.
- Sequence order for stage s:
  - Counter c runs 0..N/2-1.
  - k = (c & ((N>>(s+1))-1)) << s.
  - This gives 2^s groups of N>>(s+1) twiddles.
- FSM states:
  - IDLE: start with busy=0:
    - stage < LOG2N: latch stage and inverse, c=0, busy=1, go to RUN.
    - Otherwise: err=1 for one cycle, stay in IDLE.
    - start while busy=1 is ignored (no err).
  - RUN: the output register loads entry c when (!tw_valid || tw_ready), then c increments. Loading c = N/2-1 sets tw_last=1 and goes to DRAIN.
  - DRAIN: on tw_valid && tw_ready, clear tw_valid and tw_last, drop busy, go to IDLE. A start in that same cycle is ignored; the earliest next start is the following cycle.
- Latency: first tw_valid rises on the clock edge after the start-accept edge.
- Throughput: one twiddle per cycle while tw_ready=1.
- Backpressure: with tw_valid=1 and tw_ready=0, tw_data, tw_k and tw_last are held stable and c does not advance. No twiddle is dropped or duplicated.
- Stage streams are always exactly N/2 handshakes. tw_last is asserted only on the final one.
- err is cleared the cycle after it pulses. err has no effect on busy.

Test Plan:
1. LOG2N=4, start with stage=0, inverse=0, tw_ready=1 -> 8 twiddles on consecutive cycles, tw_k = 0..7:
   - k1 = {3B64,B61F}, k2 = {39A8,B9A8}, k3 = {361F,BB64}, k4 = {0000,BC00}, k5 = {B61F,BB64}, k7 = {BB64,B61F}.
   - tw_last set only with k=7; busy falls after that handshake.
2. LOG2N=4, stage=2 -> tw_k = 0,4,0,4,0,4,0,4. Then stage=3 -> eight twiddles of {3C00,0000}.
3. LOG2N=4, stage=0, inverse=1 -> k2 = {39A8,39A8}, k4 = {0000,3C00}, k0 = {3C00,0000} (no 8000).
4. tw_ready held low for 3 cycles on k=3 -> tw_data stays {361F,BB64} and tw_k stays 3 throughout. The stream resumes at k=4; the total is 8 handshakes.
5. LOG2N=6, stage=0 -> k8 = {39A8,B9A8}, k16 = {0000,BC00}, k24 = {B9A8,B9A8}, 32 handshakes. LOG2N=4, stage=4 -> err pulses one cycle, busy stays 0, no tw_valid.
6. rst asserted at the 4th twiddle -> next cycle tw_valid=0, busy=0. A subsequent stage=1 start streams k = 0,2,4,6,0,2,4,6 normally. A start asserted while busy=1 has no effect on the sequence.
